// File: rtl/traffic_phase_scheduler.sv
// Demand-actuated four-approach phase scheduler: latches requests, grants
// green round-robin (NS, EW, SN, WE) and sequences GREEN/YELLOW/ALL-RED.
module traffic_phase_scheduler #(
  parameter int unsigned MIN_GREEN   = 3,
  parameter int unsigned MAX_GREEN   = 8,
  parameter int unsigned YELLOW_TIME = 2,
  parameter int unsigned ALLRED_TIME = 1,
  parameter int unsigned CNT_W       = 4
) (
  input  logic       CLK,
  input  logic       CLEAR,
  input  logic [3:0] REQ,
  output logic [1:0] NS,
  output logic [1:0] SN,
  output logic [1:0] EW,
  output logic [1:0] WE,
  output logic [1:0] ACTIVE,
  output logic       PHASE_DONE
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GREEN  = 2'd1,
    S_YELLOW = 2'd2,
    S_ALLRED = 2'd3
  } state_e;

  localparam logic [1:0] L_RED = 2'b00;
  localparam logic [1:0] L_YEL = 2'b01;
  localparam logic [1:0] L_GRN = 2'b10;

  localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YEL_LAST = CNT_W'(YELLOW_TIME - 1);
  localparam logic [CNT_W-1:0] AR_LAST  = CNT_W'(ALLRED_TIME - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  timer_q, timer_d;
  logic [3:0]        pending_q, pending_d;
  logic [1:0]        last_q, last_d;
  logic [1:0]        active_q, active_d;
  logic [3:0][1:0]   lights_q, lights_d;
  logic              phase_done_q, phase_done_d;

  logic [3:0]        eff;
  logic [3:0]        active_mask;
  logic              other;
  logic [1:0]        pick;
  logic              pick_vld;
  logic              grant;
  logic [1:0]        idx;

  // Round-robin search over outstanding demand, starting after the last grant.
  always_comb begin
    eff         = pending_q | REQ;
    active_mask = 4'b0001 << active_q;
    other       = |(eff & ~active_mask);
    pick        = 2'd0;
    pick_vld    = 1'b0;
    idx         = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      idx = last_q + 2'(i);
      if (!pick_vld && eff[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
    end
  end

  // Next-state, timer, demand bookkeeping and light decode.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    last_d    = last_q;
    active_d  = active_q;
    pending_d = pending_q | REQ;
    grant     = 1'b0;
    lights_d  = {4{L_RED}};

    if (state_q == S_GREEN) begin
      pending_d[active_q] = pending_q[active_q];
    end

    case (state_q)
      S_IDLE: begin
        grant = pick_vld;
      end
      S_GREEN: begin
        if (other && ((timer_q >= MIN_LAST && !REQ[active_q]) || timer_q == MAX_LAST)) begin
          state_d = S_YELLOW;
          timer_d = '0;
        end else if (timer_q != MAX_LAST) begin
          timer_d = timer_q + CNT_ONE;
        end
      end
      S_YELLOW: begin
        if (timer_q == YEL_LAST) begin
          state_d = S_ALLRED;
          timer_d = '0;
        end else begin
          timer_d = timer_q + CNT_ONE;
        end
      end
      S_ALLRED: begin
        if (timer_q == AR_LAST) begin
          grant   = pick_vld;
          state_d = S_IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase

    if (grant) begin
      state_d         = S_GREEN;
      timer_d         = '0;
      active_d        = pick;
      last_d          = pick;
      pending_d[pick] = 1'b0;
    end

    // Outputs are decoded from next state so they register alongside it.
    if (state_d == S_GREEN) begin
      lights_d[active_d] = L_GRN;
    end else if (state_d == S_YELLOW) begin
      lights_d[active_d] = L_YEL;
    end
    phase_done_d = (state_d == S_ALLRED) && (timer_d == AR_LAST);
  end

  always_ff @(posedge CLK) begin
    if (CLEAR) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      pending_q    <= '0;
      last_q       <= 2'd3;
      active_q     <= 2'd0;
      lights_q     <= {4{L_RED}};
      phase_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      pending_q    <= pending_d;
      last_q       <= last_d;
      active_q     <= active_d;
      lights_q     <= lights_d;
      phase_done_q <= phase_done_d;
    end
  end

  assign NS         = lights_q[0];
  assign EW         = lights_q[1];
  assign SN         = lights_q[2];
  assign WE         = lights_q[3];
  assign ACTIVE     = active_q;
  assign PHASE_DONE = phase_done_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Self-checking bench for traffic_phase_scheduler: vector table, directed
// phase sequences and random demand against a phase-level reference model.
module tb_traffic_phase_scheduler;

  localparam int MIN_G = 3;
  localparam int MAX_G = 8;
  localparam int Y_T   = 2;
  localparam int AR_T  = 1;

  logic       CLK = 1'b0;
  logic       CLEAR;
  logic [3:0] REQ;
  logic [1:0] NS, SN, EW, WE, ACTIVE;
  logic       PHASE_DONE;

  always #5 CLK = ~CLK;

  traffic_phase_scheduler #(
    .MIN_GREEN(MIN_G), .MAX_GREEN(MAX_G), .YELLOW_TIME(Y_T),
    .ALLRED_TIME(AR_T), .CNT_W(4)
  ) dut (
    .CLK(CLK), .CLEAR(CLEAR), .REQ(REQ),
    .NS(NS), .SN(SN), .EW(EW), .WE(WE),
    .ACTIVE(ACTIVE), .PHASE_DONE(PHASE_DONE)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: phase kind (0 idle, 1 green, 2 yellow, 3 all-red),
  // cycles elapsed in the phase (unsaturated), served approach, demand set.
  int         m_phase = 0;
  int         m_el    = 0;
  int         m_act   = 0;
  int         m_last  = 3;
  logic [3:0] m_pend  = 4'b0000;

  task automatic model_step(input logic clr, input logic [3:0] req);
    logic [3:0] eff;
    logic [3:0] np;
    bit         grant;
    bit         other;
    bit         found;
    int         pick;
    if (clr) begin
      m_phase = 0; m_el = 0; m_act = 0; m_last = 3; m_pend = 4'b0000;
      return;
    end
    eff   = m_pend | req;
    np    = m_pend | req;
    grant = 0;
    if (m_phase == 1) np[m_act] = m_pend[m_act];
    other = 0;
    for (int a = 0; a < 4; a++) if (a != m_act && eff[a]) other = 1;
    case (m_phase)
      0: grant = (eff != 4'b0000);
      1: begin
        if (other && (m_el >= MAX_G - 1 || (m_el >= MIN_G - 1 && !req[m_act]))) begin
          m_phase = 2; m_el = 0;
        end else m_el++;
      end
      2: begin
        if (m_el + 1 == Y_T) begin m_phase = 3; m_el = 0; end
        else m_el++;
      end
      default: begin
        if (m_el + 1 == AR_T) begin
          if (eff != 4'b0000) grant = 1;
          else begin m_phase = 0; m_el = 0; end
        end else m_el++;
      end
    endcase
    if (grant) begin
      found = 0;
      pick  = 0;
      for (int i = 1; i <= 4; i++) begin
        if (!found && eff[(m_last + i) % 4]) begin
          pick  = (m_last + i) % 4;
          found = 1;
        end
      end
      m_phase = 1; m_el = 0; m_act = pick; m_last = pick;
      np[pick] = 1'b0;
    end
    m_pend = np;
  endtask

  function automatic logic [10:0] model_out();
    logic [1:0] l [4];
    for (int a = 0; a < 4; a++) begin
      l[a] = 2'b00;
      if (a == m_act && m_phase == 1) l[a] = 2'b10;
      if (a == m_act && m_phase == 2) l[a] = 2'b01;
    end
    return {l[0], l[1], l[2], l[3], 2'(m_act), (m_phase == 3 && m_el == AR_T - 1)};
  endfunction

  function automatic logic [10:0] dut_out();
    return {NS, EW, SN, WE, ACTIVE, PHASE_DONE};
  endfunction

  function automatic int green_idx();
    if (NS == 2'b10) return 0;
    if (EW == 2'b10) return 1;
    if (SN == 2'b10) return 2;
    if (WE == 2'b10) return 3;
    return -1;
  endfunction

  task automatic expect_eq(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // Apply one cycle of inputs, advance the model, compare all outputs.
  task automatic tick(input logic clr, input logic [3:0] req, input string name);
    logic [10:0] exp;
    CLEAR = clr;
    REQ   = req;
    @(posedge CLK);
    model_step(clr, req);
    #1;
    exp = model_out();
    n_cmp++;
    if (dut_out() !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got {NS,EW,SN,WE,ACT,PD}=%b want %b", name, $time, dut_out(), exp);
    end
  endtask

  typedef struct {
    logic        clr;
    logic [3:0]  req;
    logic [10:0] exp;   // {NS,EW,SN,WE,ACTIVE,PHASE_DONE}
  } vec_t;

  vec_t tbl [10];

  typedef struct { int t; int a; } start_t;

  task automatic collect_starts(input logic [3:0] req, input int cycles, input string name,
                                output start_t st[$], output int side_green);
    int prev;
    int cur;
    prev = -1;
    side_green = 0;
    st.delete();
    for (int c = 0; c < cycles; c++) begin
      tick(1'b0, req, name);
      cur = green_idx();
      if (cur >= 0 && cur != prev) st.push_back('{c, cur});
      if (cur == 1 || cur == 2) side_green++;
      prev = cur;
    end
  endtask

  initial begin
    start_t st[$];
    int     side;
    int     cnt;
    int     bad;
    bit     seen;
    logic [3:0] r;
    int     dens;

    CLEAR = 1'b1;
    REQ   = 4'b0000;

    // Reset, release with NS request, gap-out to EW, then EW rests.
    tbl[0] = '{1'b1, 4'b1111, 11'b00_00_00_00_00_0};
    tbl[1] = '{1'b1, 4'b1111, 11'b00_00_00_00_00_0};
    tbl[2] = '{1'b0, 4'b0001, 11'b10_00_00_00_00_0};
    tbl[3] = '{1'b0, 4'b0010, 11'b10_00_00_00_00_0};
    tbl[4] = '{1'b0, 4'b0000, 11'b10_00_00_00_00_0};
    tbl[5] = '{1'b0, 4'b0000, 11'b01_00_00_00_00_0};
    tbl[6] = '{1'b0, 4'b0000, 11'b01_00_00_00_00_0};
    tbl[7] = '{1'b0, 4'b0000, 11'b00_00_00_00_00_1};
    tbl[8] = '{1'b0, 4'b0000, 11'b00_10_00_00_01_0};
    tbl[9] = '{1'b0, 4'b0000, 11'b00_10_00_00_01_0};

    for (int i = 0; i < 10; i++) begin
      tick(tbl[i].clr, tbl[i].req, "table_model");
      n_cmp++;
      if (dut_out() !== tbl[i].exp) begin
        n_bad++;
        $display("FAIL table[%0d]: got %b want %b", i, dut_out(), tbl[i].exp);
      end
    end

    // Rest on green: lone NS demand holds green with no phase-done pulse.
    tick(1'b1, 4'b0000, "rest_clr");
    bad = 0;
    for (int c = 0; c < 30; c++) begin
      tick(1'b0, 4'b0001, "rest");
      if (NS != 2'b10 || EW != 2'b00 || SN != 2'b00 || WE != 2'b00 || PHASE_DONE) bad++;
    end
    expect_eq("rest_bad_cycles", bad, 0);

    // Max-out: NS held, EW pulsed -> NS green exactly MAX_G cycles, then EW.
    tick(1'b1, 4'b0000, "max_clr");
    tick(1'b0, 4'b0001, "max");
    cnt = (NS == 2'b10) ? 1 : 0;
    tick(1'b0, 4'b0011, "max");
    if (NS == 2'b10) cnt++;
    for (int c = 0; c < 20; c++) begin
      tick(1'b0, 4'b0001, "max");
      if (NS != 2'b10) break;
      cnt++;
    end
    expect_eq("max_green_len", cnt, MAX_G);
    expect_eq("max_ns_yellow", int'(NS), 1);
    tick(1'b0, 4'b0001, "max");
    tick(1'b0, 4'b0001, "max");
    expect_eq("max_phase_done", int'(PHASE_DONE), 1);
    tick(1'b0, 4'b0001, "max");
    expect_eq("max_then_ew", int'(EW), 2);

    // Round robin with all demand held.
    tick(1'b1, 4'b0000, "rr_clr");
    collect_starts(4'b1111, 60, "rr", st, side);
    expect_eq("rr_starts_found", (st.size() >= 5) ? 1 : 0, 1);
    if (st.size() >= 5) begin
      for (int k = 0; k < 5; k++) expect_eq("rr_order", st[k].a, k % 4);
      expect_eq("rr_ns_period", st[4].t - st[0].t, 44);
      expect_eq("rr_phase_len", st[1].t - st[0].t, MAX_G + Y_T + AR_T);
    end

    // Skip check: only NS and WE ask.
    tick(1'b1, 4'b0000, "skip_clr");
    collect_starts(4'b1001, 40, "skip", st, side);
    expect_eq("skip_side_green", side, 0);
    expect_eq("skip_starts_found", (st.size() >= 2) ? 1 : 0, 1);
    if (st.size() >= 2) begin
      expect_eq("skip_first", st[0].a, 0);
      expect_eq("skip_second", st[1].a, 3);
    end

    // Reset in EW yellow cycle 1 with SN pending.
    tick(1'b1, 4'b0000, "rsty_clr");
    tick(1'b0, 4'b0010, "rsty");
    expect_eq("rsty_ew_green", int'(EW), 2);
    tick(1'b0, 4'b0100, "rsty");
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      tick(1'b0, 4'b0000, "rsty");
      if (EW == 2'b01) begin seen = 1; break; end
    end
    expect_eq("rsty_yellow_reached", int'(seen), 1);
    tick(1'b0, 4'b0000, "rsty");
    expect_eq("rsty_yellow_c1", int'(EW), 1);
    tick(1'b1, 4'b0000, "rsty");
    expect_eq("rsty_all_red", int'({NS, EW, SN, WE}), 0);
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      tick(1'b0, 4'b0000, "rsty_idle");
      if ({NS, EW, SN, WE} != 8'h00) bad++;
    end
    expect_eq("rsty_stays_idle", bad, 0);
    tick(1'b0, 4'b0100, "rsty");
    expect_eq("rsty_sn_green", int'(SN), 2);

    // Random demand with occasional clears, varying density.
    dens = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 150 == 0) dens = $urandom_range(0, 3);
      r = 4'($urandom);
      case (dens)
        0: r = r & 4'($urandom) & 4'($urandom);
        1: r = r & 4'($urandom);
        2: r = r;
        default: r = r | 4'($urandom);
      endcase
      tick(($urandom_range(0, 199) == 0), r, "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
